bankr_wr_arbiter: RTL

Write-port arbiter and sequencer for the 32x32 register bank. It merges two write sources onto the bank's single write port (Rw/Dir/DIn): source A, the single-cycle ALU writeback, and source B, a variable-latency unit such as load or multiply, which uses a valid/ready handshake. B writes wait in a small in-order queue while A holds the port. The block also flags read hazards against queued writes, so the hazard/stall logic can hold the reader.

---
 rtl/bankr_wr_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/bankr_wr_arbiter.sv
// Write-port arbiter for the 32x32 register bank: single-cycle source A has strict
// priority, variable-latency source B waits in an in-order queue with hazard flags.
module bankr_wr_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        A_Wen,
    input  logic [4:0]  A_Dir,
    input  logic [31:0] A_DIn,
    input  logic        B_Valid,
    output logic        B_Ready,
    input  logic [4:0]  B_Dir,
    input  logic [31:0] B_DIn,
    input  logic [4:0]  Rd1,
    input  logic [4:0]  Rd2,
    output logic        Haz1,
    output logic        Haz2,
    output logic        Rw,
    output logic [4:0]  Dir,
    output logic [31:0] DIn,
    output logic [2:0]  Pend
);
    localparam int              PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]      DEPTH_CNT = 3'(DEPTH);
    localparam logic [PW-1:0]   LAST      = PW'(DEPTH - 1);

    logic [DEPTH-1:0] q_valid;
    logic [4:0]       q_dir  [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             a_go;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Register 0 is hardwired, so a write to it is no request at all.
    assign a_go    = A_Wen && (A_Dir != 5'd0);
    assign B_Ready = !rst && (Pend < DEPTH_CNT);
    assign push    = B_Valid && B_Ready && (B_Dir != 5'd0);
    assign pop     = !a_go && (Pend != 3'd0);

    // NOTE: payload storage carries no reset; only the valid bits and pointers need one.
    always_ff @(posedge clk) begin
        if (push) begin
            q_dir[tail]  <= B_Dir;
            q_data[tail] <= B_DIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= '0;
            head    <= '0;
            tail    <= '0;
            Pend    <= '0;
            Rw      <= 1'b0;
            Dir     <= '0;
            DIn     <= '0;
        end else begin
            // A is the newer producer, so older queued writes to its target die.
            for (int i = 0; i < DEPTH; i++) begin
                if (a_go && (q_dir[i] == A_Dir)) q_valid[i] <= 1'b0;
            end
            if (pop) begin
                q_valid[head] <= 1'b0;
                head          <= nxt(head);
            end
            if (push) begin
                q_valid[tail] <= !(a_go && (B_Dir == A_Dir));
                tail          <= nxt(tail);
            end

            case ({push, pop})
                2'b10:   Pend <= Pend + 3'd1;
                2'b01:   Pend <= Pend - 3'd1;
                default: Pend <= Pend;
            endcase

            if (a_go) begin
                Rw  <= 1'b1;
                Dir <= A_Dir;
                DIn <= A_DIn;
            end else if (pop) begin
                Rw <= q_valid[head];
                if (q_valid[head]) begin
                    Dir <= q_dir[head];
                    DIn <= q_data[head];
                end
            end else begin
                Rw <= 1'b0;
            end
        end
    end

    always_comb begin
        Haz1 = 1'b0;
        Haz2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && (Rd1 != 5'd0) && (q_dir[i] == Rd1)) Haz1 = 1'b1;
            if (q_valid[i] && (Rd2 != 5'd0) && (q_dir[i] == Rd2)) Haz2 = 1'b1;
        end
    end
endmodule
